// File: rtl/ramp_pkg.sv
// rtl/ramp_pkg.sv - shared constants and state type for the ramp PWM block
package ramp_pkg;

    localparam int RAMP_W_DEF = 7;
    localparam int MAX_RAMP   = (1 << RAMP_W_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/ramp_step_check.sv
// rtl/ramp_step_check.sv - previous-sample tracker producing step and wrap indications
module ramp_step_check
    import ramp_pkg::*;
#(
    parameter int RAMP_W = RAMP_W_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [RAMP_W-1:0] i_data_in,
    output logic              o_wrap,
    output logic              o_good_step,
    output logic              o_first_sample
);

    localparam logic [RAMP_W-1:0] L_MAX = {RAMP_W{1'b1}};

    logic [RAMP_W-1:0] r_prev;
    logic              r_seen;
    logic [RAMP_W-1:0] w_prev_inc;

    assign w_prev_inc = r_prev + 1'b1;

    // Every enabled sample becomes the reference for the next step check.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_prev <= '0;
            r_seen <= 1'b0;
        end else if (i_enable) begin
            r_prev <= i_data_in;
            r_seen <= 1'b1;
        end
    end

    // No step can be judged until one sample has been seen.
    assign o_first_sample = i_enable & ~r_seen;
    assign o_good_step    = i_enable & r_seen & (i_data_in == w_prev_inc);
    assign o_wrap         = i_enable & r_seen & (r_prev == L_MAX) & (i_data_in == '0);

endmodule

// File: rtl/ramp_pwm.sv
// rtl/ramp_pwm.sv - PWM generator locked to an external ramp with wrap-aligned duty updates
module ramp_pwm
    import ramp_pkg::*;
#(
    parameter int                RAMP_W     = RAMP_W_DEF,
    parameter int                CNT_W      = 8,
    parameter logic [RAMP_W-1:0] DUTY_RESET = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [RAMP_W-1:0] data_in,
    input  logic [RAMP_W-1:0] duty_in,
    input  logic              duty_load,
    output logic              duty_busy,
    output logic              pwm_out,
    output logic              wrap_pulse,
    output logic [CNT_W-1:0]  period_count,
    output logic              locked,
    output logic              step_error
);

    ramp_state_t       r_state;
    ramp_state_t       w_state_next;
    logic              w_wrap;
    logic              w_good;
    logic              w_first;
    logic              w_wrap_edge;
    logic              w_bad;
    logic              w_accept;
    logic              w_pwm_next;
    logic [RAMP_W-1:0] w_next_active;
    logic [RAMP_W-1:0] r_active;
    logic [RAMP_W-1:0] r_shadow;
    logic              r_busy;
    logic              r_pwm;
    logic              r_wrap_pulse;
    logic              r_err;
    logic [CNT_W-1:0]  r_count;

    ramp_step_check #(.RAMP_W(RAMP_W)) u_step_check (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_data_in      (data_in),
        .o_wrap         (w_wrap),
        .o_good_step    (w_good),
        .o_first_sample (w_first)
    );

    // State register for the lock FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lock FSM: decides lock transitions, step errors and the wrap edge.
    always_comb begin
        w_state_next = r_state;
        w_bad        = 1'b0;
        w_wrap_edge  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_first) w_state_next = SYNC;
            end
            SYNC: begin
                if (enable) begin
                    if (!w_good) begin
                        w_bad = 1'b1;
                    end else if (w_wrap) begin
                        w_wrap_edge  = 1'b1;
                        w_state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (enable) begin
                    if (!w_good) begin
                        w_bad        = 1'b1;
                        w_state_next = SYNC;
                    end else if (w_wrap) begin
                        w_wrap_edge = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The wrap sample itself is compared against the duty it switches to.
    always_comb begin
        w_accept      = duty_load & ~r_busy;
        w_next_active = (w_wrap_edge & r_busy) ? r_shadow : r_active;
        w_pwm_next    = enable & (w_state_next == RUN) & (data_in < w_next_active);
    end

    // Outputs, period counter and double-buffered duty.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pwm        <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_err        <= 1'b0;
            r_count      <= '0;
            r_active     <= DUTY_RESET;
            r_shadow     <= DUTY_RESET;
            r_busy       <= 1'b0;
        end else begin
            r_pwm        <= w_pwm_next;
            r_wrap_pulse <= w_wrap_edge;
            r_active     <= w_next_active;
            if (w_bad) r_err <= 1'b1;
            if (w_wrap_edge) r_count <= r_count + 1'b1;
            if (w_wrap_edge && r_busy) begin
                r_busy <= 1'b0;
            end else if (w_accept) begin
                r_shadow <= duty_in;
                r_busy   <= 1'b1;
            end
        end
    end

    assign pwm_out      = r_pwm;
    assign wrap_pulse   = r_wrap_pulse;
    assign period_count = r_count;
    assign locked       = (r_state == RUN);
    assign step_error   = r_err;
    assign duty_busy    = r_busy;

endmodule

// File: tb/tb_ramp_pwm.sv
// tb/tb_ramp_pwm.sv - self-checking bench for ramp_pwm
module tb_ramp_pwm;
    import ramp_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [6:0] data_in = '0;
    logic [6:0] duty_in = '0;
    logic       duty_load = 1'b0;
    logic       duty_busy;
    logic       pwm_out;
    logic       wrap_pulse;
    logic [7:0] period_count;
    logic       locked;
    logic       step_error;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit m_have;
    int m_prev;
    bit m_locked;
    bit m_err;
    int m_cnt;
    int m_active;
    int m_shadow;
    bit m_busy;
    bit e_pwm;
    bit e_wrap;

    logic [6:0] ramp;

    typedef struct {
        logic       en;
        logic [6:0] d;
        logic       ld;
        logic [6:0] dt;
        logic       pwm;
        logic       wrp;
        int         cnt;
        logic       lk;
        logic       err;
        logic       bsy;
    } vec_t;

    vec_t tbl[17];

    ramp_pwm #(.RAMP_W(7), .CNT_W(8), .DUTY_RESET(7'd0)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .data_in      (data_in),
        .duty_in      (duty_in),
        .duty_load    (duty_load),
        .duty_busy    (duty_busy),
        .pwm_out      (pwm_out),
        .wrap_pulse   (wrap_pulse),
        .period_count (period_count),
        .locked       (locked),
        .step_error   (step_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit en, input int d, input int dt, input bit ld);
        bit accept;
        e_pwm  = 0;
        e_wrap = 0;
        if (rst) begin
            m_have = 0; m_prev = 0; m_locked = 0; m_err = 0; m_cnt = 0;
            m_active = 0; m_shadow = 0; m_busy = 0;
            return;
        end
        accept = ld && !m_busy;
        if (en) begin
            if (m_have) begin
                if (d != (m_prev + 1) % 128) begin
                    m_err    = 1;
                    m_locked = 0;
                end else if (m_prev == 127 && d == 0) begin
                    m_locked = 1;
                    e_wrap   = 1;
                    m_cnt    = (m_cnt + 1) % 256;
                    if (m_busy) begin
                        m_active = m_shadow;
                        m_busy   = 0;
                    end
                end
                if (m_locked) e_pwm = (d < m_active);
            end
            m_have = 1;
            m_prev = d;
        end
        if (accept) begin
            m_shadow = dt;
            m_busy   = 1;
        end
    endtask

    task automatic step(input bit rst, input bit en, input logic [6:0] d,
                        input logic [6:0] dt, input bit ld);
        reset     = rst;
        enable    = en;
        data_in   = d;
        duty_in   = dt;
        duty_load = ld;
        @(posedge clock);
        #1;
        model_edge(rst, en, int'(d), int'(dt), ld);
        chk("pwm_out", pwm_out, e_pwm);
        chk("wrap_pulse", wrap_pulse, e_wrap);
        chk("period_count", period_count, m_cnt);
        chk("locked", locked, m_locked);
        chk("step_error", step_error, m_err);
        chk("duty_busy", duty_busy, m_busy);
    endtask

    // one full ramp period starting at the wrap sample; returns the high count
    task automatic run_period(input int la1, input logic [6:0] lv1,
                              input int la2, input logic [6:0] lv2, output int highs);
        highs = 0;
        for (int i = 0; i < 128; i++) begin
            ramp = ramp + 7'd1;
            if (i == la1)      step(0, 1, ramp, lv1, 1);
            else if (i == la2) step(0, 1, ramp, lv2, 1);
            else               step(0, 1, ramp, 7'd0, 0);
            if (i == la1) chk("busy_after_load", duty_busy, 1);
            if (pwm_out) highs++;
        end
    endtask

    initial begin
        int         highs;
        bit         r_rst;
        bit         r_en;
        bit         r_ld;
        logic [6:0] r_dt;

        tbl[0]  = '{1'b1, 7'd125, 1'b1, 7'd3,  1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 7'd126, 1'b0, 7'd0,  1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 7'd127, 1'b0, 7'd0,  1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 7'd0,   1'b0, 7'd0,  1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 7'd1,   1'b0, 7'd0,  1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 7'd2,   1'b0, 7'd0,  1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 7'd3,   1'b0, 7'd0,  1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 7'd3,   1'b0, 7'd0,  1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 7'd4,   1'b0, 7'd0,  1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 7'd9,   1'b0, 7'd0,  1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 7'd10,  1'b0, 7'd0,  1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 7'd127, 1'b0, 7'd0,  1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 7'd0,   1'b0, 7'd0,  1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 7'd1,   1'b1, 7'd0,  1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 7'd2,   1'b1, 7'd50, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 7'd127, 1'b0, 7'd0,  1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{1'b1, 7'd0,   1'b0, 7'd0,  1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0};

        // reset state
        step(1, 0, 7'd0, 7'd0, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_lock", locked, 0);
        chk("rst_cnt", period_count, 0);
        chk("rst_busy", duty_busy, 0);

        // directed vector table
        for (int i = 0; i < 17; i++) begin
            step(0, tbl[i].en, tbl[i].d, tbl[i].dt, tbl[i].ld);
            chk("tbl_pwm", pwm_out, tbl[i].pwm);
            chk("tbl_wrap", wrap_pulse, tbl[i].wrp);
            chk("tbl_cnt", period_count, tbl[i].cnt);
            chk("tbl_lock", locked, tbl[i].lk);
            chk("tbl_err", step_error, tbl[i].err);
            chk("tbl_busy", duty_busy, tbl[i].bsy);
        end

        // full periods: duty 32, then 100, 0, 127
        step(1, 0, 7'd0, 7'd0, 0);
        ramp = 7'd0;
        step(0, 1, ramp, 7'd32, 1);
        for (int i = 0; i < 127; i++) begin
            ramp = ramp + 7'd1;
            step(0, 1, ramp, 7'd0, 0);
        end
        chk("prelock_locked", locked, 0);
        run_period(60, 7'd100, 80, 7'd5, highs);
        chk("period1_highs", highs, 32);
        chk("period1_count", period_count, 1);
        run_period(20, 7'd0, -1, 7'd0, highs);
        chk("period2_highs", highs, 100);
        chk("period2_count", period_count, 2);
        run_period(5, 7'd127, -1, 7'd0, highs);
        chk("period3_highs", highs, 0);
        run_period(5, 7'd32, -1, 7'd0, highs);
        chk("period4_highs", highs, 127);
        chk("period4_count", period_count, 4);

        // ramp glitch 40 -> 45 while running
        for (int i = 0; i < 41; i++) begin
            ramp = ramp + 7'd1;
            step(0, 1, ramp, 7'd0, 0);
        end
        ramp = 7'd45;
        step(0, 1, ramp, 7'd0, 0);
        chk("glitch_err", step_error, 1);
        chk("glitch_lock", locked, 0);
        chk("glitch_pwm", pwm_out, 0);
        chk("glitch_cnt", period_count, 5);
        while (ramp != 7'd127) begin
            ramp = ramp + 7'd1;
            step(0, 1, ramp, 7'd0, 0);
            chk("sync_lock", locked, 0);
        end
        ramp = 7'd0;
        step(0, 1, ramp, 7'd0, 0);
        chk("relock_lock", locked, 1);
        chk("relock_cnt", period_count, 6);
        chk("relock_err_sticky", step_error, 1);

        // enable dropped for 10 cycles with the ramp frozen
        for (int i = 0; i < 20; i++) begin
            ramp = ramp + 7'd1;
            step(0, 1, ramp, 7'd0, 0);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, ramp, 7'd0, 0);
            chk("hold_pwm", pwm_out, 0);
            chk("hold_cnt", period_count, 6);
        end
        ramp = ramp + 7'd1;
        step(0, 1, ramp, 7'd0, 0);
        chk("resume_lock", locked, 1);
        chk("resume_pwm", pwm_out, 1);

        // reset during a high phase with a duty pending
        ramp = ramp + 7'd1;
        step(0, 1, ramp, 7'd90, 1);
        ramp = ramp + 7'd1;
        step(0, 1, ramp, 7'd0, 0);
        chk("prereset_busy", duty_busy, 1);
        chk("prereset_pwm", pwm_out, 1);
        step(1, 1, ramp + 7'd1, 7'd0, 0);
        chk("midreset_pwm", pwm_out, 0);
        chk("midreset_busy", duty_busy, 0);
        chk("midreset_lock", locked, 0);
        ramp = 7'd0;
        step(0, 1, ramp, 7'd0, 0);
        for (int i = 0; i < 127; i++) begin
            ramp = ramp + 7'd1;
            step(0, 1, ramp, 7'd0, 0);
        end
        run_period(-1, 7'd0, -1, 7'd0, highs);
        chk("discarded_duty_highs", highs, 0);
        chk("after_reset_count", period_count, 1);

        // randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 999) < 3);
            r_en  = ($urandom_range(0, 9) != 0);
            if (r_en) begin
                if ($urandom_range(0, 59) == 0) ramp = 7'($urandom_range(0, MAX_RAMP));
                else ramp = ramp + 7'd1;
            end
            r_ld = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       r_dt = 7'd0;
                1:       r_dt = 7'd127;
                default: r_dt = 7'($urandom_range(0, MAX_RAMP));
            endcase
            step(r_rst, r_en, ramp, r_dt, r_ld);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ramp_pwm.md
Name: ramp_pwm

Overview:
- Downstream consumer of the 7-bit ramp counter: uses ramp value as PWM carrier, compares it against a programmable duty.
- Emits registered PWM, one-cycle wrap strobe per ramp period, and a period count.
- Checks ramp integrity (+1 per enabled cycle); loses lock on any bad step.
- Duty updates are double-buffered and take effect only at ramp wrap, so periods are never glitched.

Parameters:
- RAMP_W, 7, width of ramp sample and duty.
- CNT_W, 8, width of period counter.
- DUTY_RESET, 0, active and shadow duty value after reset.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- enable  in  1  same enable that drives the ramp; samples are valid only when high.
- data_in  in  RAMP_W  ramp value (ramp data_out).
- duty_in  in  RAMP_W  requested duty (high count per period).
- duty_load  in  1  request to capture duty_in.
- duty_busy  out  1  high while a captured duty is pending; loads ignored while high.
- pwm_out  out  1  registered PWM output.
- wrap_pulse  out  1  one-cycle strobe on detected wrap.
- period_count  out  CNT_W  wraps counted since lock; rolls over 2^CNT_W-1 -> 0.
- locked  out  1  high in RUN.
- step_error  out  1  sticky; set on a bad step; cleared only by reset.

Behaviour:
- Reset values: pwm_out=0, wrap_pulse=0, period_count=0, locked=0, step_error=0, duty_busy=0, active=shadow=DUTY_RESET, prev=0, state=IDLE.
- Cycles with enable=0: no sample processed; prev, state and counters hold; pwm_out=0; wrap_pulse=0.
- Duty load handshake:
  - A load is accepted when duty_load=1 and duty_busy=0, regardless of enable. Then shadow<=duty_in and duty_busy<=1.
  - A load with duty_busy=1 is dropped.
- Wrap: enable=1, prev=2^RAMP_W-1, data_in=0.
- Good step: enable=1, data_in == prev+1 mod 2^RAMP_W (includes wrap).
- FSM:
  - IDLE: first enabled sample -> prev<=data_in, go to SYNC. No step check on this sample.
  - SYNC: locked=0, pwm_out=0. Bad step -> step_error<=1, stay in SYNC. Wrap -> RUN. Every enabled sample updates prev.
  - RUN: locked=1. Bad step -> step_error<=1, go to SYNC, locked<=0, pwm_out<=0; period_count holds.
- Wrap edge (SYNC->RUN entry or in RUN):
  - wrap_pulse<=1 for exactly one cycle; period_count<=period_count+1.
  - If duty_busy: active<=shadow, duty_busy<=0.
  - A duty_load accepted in the same cycle captures into shadow and applies at the following wrap, not this one.
- PWM in RUN, enabled cycle: pwm_out<=(data_in < next_active), where next_active is the value active takes on this edge. Latency: 1 clock from sample to pwm_out.
- Duty boundaries: duty 0 -> pwm_out always 0; duty 127 -> high 127 of 128 cycles; never 100% at RAMP_W=7.
- Unsigned comparison, RAMP_W bits; no saturation.
- Reset mid-operation: all outputs return to reset values next edge; a pending shadow is discarded.

Decomposition:
- Shared package ramp_pkg: RAMP_W default constant, state enum {IDLE, SYNC, RUN}, MAX_RAMP constant (2^RAMP_W-1).
- One sub-module ramp_step_check: holds prev and produces combinational wrap, good_step and first_sample indications. FSM, duty buffering and PWM stay in the top.

Test Plan:
- Reset; enable=1 with ramp from 0; duty loaded 32 before first wrap -> locked=1 after first 127->0; then per 128-cycle period pwm_out high for 32 cycles, low for 96; wrap_pulse once per period; period_count 1,2,3...
- duty_load=1 with duty_in=100 mid-period while active=32 -> duty_busy=1 immediately; period stays 32; next period high for 100 cycles; duty_busy drops on that wrap edge.
- Second duty_load while busy (duty_in=5) -> ignored; 100 applied; then load 0 -> pwm_out stays 0 for the full period after the next wrap.
- Force data_in to jump 40->45 in RUN -> step_error=1 next edge; locked=0; pwm_out=0; relocks only after a 127->0 wrap; step_error remains 1.
- Drop enable for 10 cycles mid-period with the ramp frozen -> outputs low and held; on resume, continuation is accepted, no error, period_count unchanged.
- Assert reset during a high PWM phase with duty pending -> next edge: all outputs 0, state IDLE; the previously pending duty is not applied after relock.
